lif_neuron_multi: RTL and testbench



---
 rtl/lif_neuron_multi_if.sv | 30 +++
 rtl/lif_neuron_multi.sv | 96 +++++++++
 tb/tb_lif_neuron_multi.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/lif_neuron_multi_if.sv
// Bus bundle for the multi-synapse LIF neuron: step enable, synapse inputs,
// per-step configuration and the registered neuron outputs.
interface lif_neuron_multi_if #(
  parameter int W     = 8,
  parameter int N_SYN = 4,
  parameter int REF_W = 4,
  parameter int CNT_W = 16
) ();
  logic                   en;
  logic [N_SYN-1:0]       syn;
  logic [N_SYN*W-1:0]     weight;
  logic [$clog2(W)-1:0]   leak_shift;
  logic [W-1:0]           threshold;
  logic [W-1:0]           v_reset;
  logic [REF_W-1:0]       refractory;
  logic                   axon;
  logic [W-1:0]           v_mem;
  logic                   in_refractory;
  logic [CNT_W-1:0]       spike_cnt;

  modport master (
    output en, syn, weight, leak_shift, threshold, v_reset, refractory,
    input  axon, v_mem, in_refractory, spike_cnt
  );

  modport slave (
    input  en, syn, weight, leak_shift, threshold, v_reset, refractory,
    output axon, v_mem, in_refractory, spike_cnt
  );
endinterface

// File: rtl/lif_neuron_multi.sv
// Leaky integrate-and-fire neuron with N_SYN signed synapses, shift leak,
// clamped membrane, refractory period and a saturating spike counter.
module lif_neuron_multi #(
  parameter int W     = 8,
  parameter int N_SYN = 4,
  parameter int REF_W = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  lif_neuron_multi_if.slave bus
);
  // Wide enough that summing all weights plus the membrane never wraps.
  localparam int SUM_W = W + $clog2(N_SYN) + 2;
  localparam logic signed [SUM_W-1:0] V_MAX = {{(SUM_W-W){1'b0}}, {W{1'b1}}};

  typedef enum logic {INTEGRATE, REFRACT} state_t;

  state_t                  state, state_next;
  logic [W-1:0]            v_mem_q, v_mem_d, leak, v_next;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [REF_W-1:0]        ref_q, ref_d;
  logic                    axon_q, axon_d, fire;
  logic signed [SUM_W-1:0] syn_sum, v_calc;

  always_comb begin
    syn_sum = '0;
    for (int i = 0; i < N_SYN; i++) begin
      if (bus.syn[i]) begin
        syn_sum = syn_sum + {{(SUM_W-W){bus.weight[i*W+W-1]}}, bus.weight[i*W +: W]};
      end
    end
    leak   = (bus.leak_shift == '0) ? '0 : (v_mem_q >> bus.leak_shift);
    v_calc = $signed({{(SUM_W-W){1'b0}}, v_mem_q}) - $signed({{(SUM_W-W){1'b0}}, leak}) + syn_sum;
    if (v_calc[SUM_W-1]) begin
      v_next = '0;
    end else if (v_calc > V_MAX) begin
      v_next = '1;
    end else begin
      v_next = v_calc[W-1:0];
    end
    fire = (state == INTEGRATE) && (v_next >= bus.threshold);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= INTEGRATE;
      v_mem_q <= '0;
      axon_q  <= 1'b0;
      cnt_q   <= '0;
      ref_q   <= '0;
    end else if (bus.en) begin
      state   <= state_next;
      v_mem_q <= v_mem_d;
      axon_q  <= axon_d;
      cnt_q   <= cnt_d;
      ref_q   <= ref_d;
    end else begin
      axon_q  <= 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      INTEGRATE: if (fire && (bus.refractory != '0)) state_next = REFRACT;
      REFRACT:   if (ref_q <= REF_W'(1)) state_next = INTEGRATE;
      default:   state_next = INTEGRATE;
    endcase
  end

  // Refractory steps hold the membrane at its post-spike value and ignore synapses.
  always_comb begin
    v_mem_d = v_mem_q;
    axon_d  = 1'b0;
    cnt_d   = cnt_q;
    ref_d   = ref_q;
    if (state == INTEGRATE) begin
      if (fire) begin
        axon_d  = 1'b1;
        v_mem_d = bus.v_reset;
        cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        if (bus.refractory != '0) ref_d = bus.refractory;
      end else begin
        v_mem_d = v_next;
      end
    end else begin
      ref_d = ref_q - 1'b1;
    end
  end

  assign bus.axon          = axon_q;
  assign bus.v_mem         = v_mem_q;
  assign bus.in_refractory = (state == REFRACT);
  assign bus.spike_cnt     = cnt_q;
endmodule

// File: tb/tb_lif_neuron_multi.sv
// Self-checking bench for lif_neuron_multi: directed scenarios followed by
// randomized steps, all compared against an integer reference model.
module tb_lif_neuron_multi;
  localparam int W     = 8;
  localparam int N_SYN = 4;
  localparam int REF_W = 4;
  localparam int CNT_W = 6;
  localparam int V_TOP = (1 << W) - 1;
  localparam int C_TOP = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lif_neuron_multi_if #(.W(W), .N_SYN(N_SYN), .REF_W(REF_W), .CNT_W(CNT_W)) bus ();

  lif_neuron_multi #(.W(W), .N_SYN(N_SYN), .REF_W(REF_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int m_v, m_cnt, m_ref, m_axon;
  logic signed [W-1:0] wt [N_SYN];

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: m_ref counts remaining refractory steps; arithmetic in plain ints.
  task automatic modelStep();
    int sum, vn;
    if (rst) begin
      m_v = 0; m_cnt = 0; m_ref = 0; m_axon = 0;
    end else if (!bus.en) begin
      m_axon = 0;
    end else if (m_ref > 0) begin
      m_ref--;
      m_axon = 0;
    end else begin
      sum = 0;
      for (int i = 0; i < N_SYN; i++) if (bus.syn[i]) sum += int'(wt[i]);
      vn = m_v + sum;
      if (bus.leak_shift != 0) vn -= (m_v >> bus.leak_shift);
      if (vn < 0) vn = 0;
      if (vn > V_TOP) vn = V_TOP;
      if (vn >= int'(bus.threshold)) begin
        m_axon = 1;
        m_v    = int'(bus.v_reset);
        if (m_cnt < C_TOP) m_cnt++;
        m_ref  = int'(bus.refractory);
      end else begin
        m_axon = 0;
        m_v    = vn;
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [N_SYN-1:0] s, input string tag);
    rst     = r;
    bus.en  = e;
    bus.syn = s;
    for (int i = 0; i < N_SYN; i++) bus.weight[i*W +: W] = wt[i];
    #1;
    modelStep();
    @(posedge clk);
    #1;
    checkOutput({tag, ".v_mem"}, int'(bus.v_mem), m_v);
    checkOutput({tag, ".axon"}, int'(bus.axon), m_axon);
    checkOutput({tag, ".cnt"}, int'(bus.spike_cnt), m_cnt);
    checkOutput({tag, ".inref"}, int'(bus.in_refractory), (m_ref > 0) ? 1 : 0);
  endtask

  task automatic setCfg(input int ls, input int thr, input int vr, input int rf);
    bus.leak_shift = ls[$clog2(W)-1:0];
    bus.threshold  = thr[W-1:0];
    bus.v_reset    = vr[W-1:0];
    bus.refractory = rf[REF_W-1:0];
  endtask

  initial begin
    for (int i = 0; i < N_SYN; i++) wt[i] = W'($urandom);
    setCfg(0, 50, 0, 0);
    m_v = 0; m_cnt = 0; m_ref = 0; m_axon = 0;

    applyStimulus(1'b1, 1'b1, 4'hF, "rst0");
    applyStimulus(1'b1, 1'b1, 4'hF, "rst1");
    checkOutput("rst_vmem", int'(bus.v_mem), 0);
    checkOutput("rst_cnt", int'(bus.spike_cnt), 0);

    for (int i = 0; i < N_SYN; i++) wt[i] = '0;
    wt[0] = 8'sd10;
    for (int k = 1; k <= 6; k++) applyStimulus(1'b0, 1'b1, 4'b0001, $sformatf("int%0d", k));
    checkOutput("int_final_v", int'(bus.v_mem), 10);
    checkOutput("int_final_cnt", int'(bus.spike_cnt), 1);

    applyStimulus(1'b1, 1'b1, 4'b0000, "rst_leak");
    wt[0] = 8'sd64;
    setCfg(2, 255, 0, 0);
    for (int k = 1; k <= 4; k++) applyStimulus(1'b0, 1'b1, 4'b0001, $sformatf("leak%0d", k));
    checkOutput("leak_v4", int'(bus.v_mem), 175);

    applyStimulus(1'b1, 1'b1, 4'b0000, "rst_inh");
    setCfg(0, 255, 0, 0);
    wt[0] = 8'sd10;
    wt[1] = -8'sd20;
    applyStimulus(1'b0, 1'b1, 4'b0001, "inh0");
    for (int k = 1; k <= 3; k++) applyStimulus(1'b0, 1'b1, 4'b0010, $sformatf("inh%0d", k));
    checkOutput("inh_floor", int'(bus.v_mem), 0);

    applyStimulus(1'b1, 1'b1, 4'b0000, "rst_sat");
    for (int i = 0; i < N_SYN; i++) wt[i] = 8'sd127;
    setCfg(0, 255, 7, 0);
    applyStimulus(1'b0, 1'b1, 4'hF, "sat");
    checkOutput("sat_axon", int'(bus.axon), 1);

    applyStimulus(1'b1, 1'b1, 4'b0000, "rst_ref");
    for (int i = 0; i < N_SYN; i++) wt[i] = '0;
    wt[0] = 8'sd60;
    setCfg(0, 50, 5, 3);
    applyStimulus(1'b0, 1'b1, 4'b0001, "ref_spk");
    applyStimulus(1'b0, 1'b1, 4'b0001, "ref_a");
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 4'b0001, $sformatf("ref_hold%0d", k));
    applyStimulus(1'b0, 1'b1, 4'b0001, "ref_b");
    applyStimulus(1'b0, 1'b1, 4'b0001, "ref_c");
    checkOutput("ref_exit", int'(bus.in_refractory), 0);
    applyStimulus(1'b0, 1'b1, 4'b0001, "ref_respk");
    checkOutput("ref_respk_axon", int'(bus.axon), 1);
    applyStimulus(1'b1, 1'b1, 4'b0001, "ref_rst");
    checkOutput("ref_rst_inref", int'(bus.in_refractory), 0);

    setCfg(0, 0, 0, 0);
    for (int k = 0; k < 70; k++) applyStimulus(1'b0, 1'b1, 4'b0000, $sformatf("cnt%0d", k));
    checkOutput("cnt_sat", int'(bus.spike_cnt), C_TOP);

    applyStimulus(1'b1, 1'b1, 4'b0000, "rst_rnd");
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N_SYN; i++) wt[i] = W'($urandom);
      setCfg(int'($urandom_range(0, W-1)), int'($urandom_range(0, V_TOP)),
             int'($urandom_range(0, V_TOP)),
             ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, (1 << REF_W) - 1)));
      applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0),
                    N_SYN'($urandom), $sformatf("rnd%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
